x_ratio_calc: RTL and testbench

//  Sequential generator for the horizontal scaler ratio.

---
 rtl/x_ratio_calc_if.sv | 14 +
 rtl/x_ratio_calc.sv | 112 +++++++++++
 tb/tb_x_ratio_calc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/x_ratio_calc_if.sv
// Request/result bundle between scale control (master) and the ratio generator (slave).
interface x_ratio_calc_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] raddr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data;

  modport master (output start, raddr, input  busy, done, data);
  modport slave  (input  start, raddr, output busy, done, data);
endinterface

// File: rtl/x_ratio_calc.sv
// Horizontal scaler ratio generator: data = floor(BASE*2^16 / (BASE+raddr)),
// produced by a 16-iteration restoring divider; 0 for raddr==0 or raddr>MAX_IDX.
module x_ratio_calc #(
  parameter int unsigned BASE    = 480,
  parameter int unsigned MAX_IDX = 240,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  x_ratio_calc_if.slave   bus
);
  localparam int unsigned DEN_W = 11;
  localparam int unsigned REM_W = 12;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nx;
  logic [DEN_W-1:0]  den, den_nx;
  logic [REM_W-1:0]  rem, rem_nx;
  logic [DATA_W-1:0] q, q_nx;
  logic [DATA_W-1:0] data, data_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              valid, valid_nx;
  logic              busy, busy_nx;
  logic              done, done_nx;

  logic [REM_W-1:0]  r2;
  logic              q_bit;
  logic [DATA_W-1:0] q_shift;
  logic              accept;

  // One restoring step: shift remainder, subtract divisor when it fits.
  always_comb begin
    r2      = {rem[REM_W-2:0], 1'b0};
    q_bit   = (r2 >= REM_W'(den));
    q_shift = {q[DATA_W-2:0], q_bit};
    accept  = bus.start && !busy;
  end

  always_comb begin
    state_nx = state;
    den_nx   = den;
    rem_nx   = rem;
    q_nx     = q;
    data_nx  = data;
    cnt_nx   = cnt;
    valid_nx = valid;
    busy_nx  = busy;
    done_nx  = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        if (accept) begin
          state_nx = CALC;
          busy_nx  = 1'b1;
          den_nx   = DEN_W'(BASE) + DEN_W'(bus.raddr);
          rem_nx   = REM_W'(BASE);
          q_nx     = '0;
          cnt_nx   = '0;
          valid_nx = (bus.raddr != '0) && (bus.raddr <= ADDR_W'(MAX_IDX));
        end
      end
      CALC: begin
        rem_nx = q_bit ? (r2 - REM_W'(den)) : r2;
        q_nx   = q_shift;
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == '1) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          data_nx  = valid ? q_shift : '0;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      den   <= '0;
      rem   <= '0;
      q     <= '0;
      data  <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      den   <= den_nx;
      rem   <= rem_nx;
      q     <= q_nx;
      data  <= data_nx;
      cnt   <= cnt_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.data = data;
endmodule

// File: tb/tb_x_ratio_calc.sv
// Directed bench for x_ratio_calc: latency, table values, invalid indices,
// busy-time start rejection, mid-run reset and start accepted in the DONE cycle.
module tb_x_ratio_calc;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  x_ratio_calc_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  x_ratio_calc #(.BASE(480), .MAX_IDX(240), .ADDR_W(10), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one job from a negedge; returns in the done cycle (at its negedge).
  task automatic run_job(input logic [9:0] a, output int lat, output int busy_n,
                         output logic [15:0] d);
    lat = 0;
    busy_n = 0;
    bus.start = 1'b1;
    bus.raddr = a;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    d = bus.data;
  endtask

  int          lat, busy_n, dones, got;
  logic [15:0] d;
  logic [31:0] exp_ratio;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.raddr = '0;
    #23;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_data", 32'(bus.data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job, latency and busy width
    run_job(10'd32, lat, busy_n, d);
    check("t1_latency", 32'(lat), 32'd17);
    check("t1_busy_cycles", 32'(busy_n), 32'd16);
    check("t1_data", 32'(d), 32'h0000_F000);
    check("t1_busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);
    check("t1_data_held", 32'(bus.data), 32'h0000_F000);
    @(negedge clk);

    // Back-to-back sweep with start held high
    bus.raddr = 10'd1;
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 240; i++) begin
      got = 0;
      for (int n = 1; n <= 40; n++) begin
        if (bus.done) begin
          got = n;
          break;
        end
        @(negedge clk);
      end
      exp_ratio = (32'd480 * 32'd65536) / (32'd480 + 32'(i));
      check("sweep_period", 32'(got), 32'd17);
      check("sweep_data", 32'(bus.data), exp_ratio);
      case (i)
        1:   check("sweep_1",   32'(bus.data), 32'h0000_FF77);
        120: check("sweep_120", 32'(bus.data), 32'h0000_CCCC);
        160: check("sweep_160", 32'(bus.data), 32'h0000_C000);
        240: check("sweep_240", 32'(bus.data), 32'h0000_AAAA);
        default: ;
      endcase
      if (i < 240) bus.raddr = 10'(i + 1);
      else bus.start = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);

    // Invalid indices overwrite previous data with 0
    run_job(10'd32, lat, busy_n, d);
    check("t3_pre0", 32'(d), 32'h0000_F000);
    run_job(10'd0, lat, busy_n, d);
    check("t3_zero_latency", 32'(lat), 32'd17);
    check("t3_zero_data", 32'(d), 32'd0);
    @(negedge clk);
    run_job(10'd32, lat, busy_n, d);
    check("t3_pre241", 32'(d), 32'h0000_F000);
    run_job(10'd241, lat, busy_n, d);
    check("t3_241_latency", 32'(lat), 32'd17);
    check("t3_241_data", 32'(d), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Start pulses during busy are ignored
    bus.start = 1'b1;
    bus.raddr = 10'd1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    busy_n = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          check("t4_data", 32'(bus.data), 32'h0000_FF77);
        end
      end
      if (n >= 3 && n <= 10) begin
        bus.start = 1'b1;
        bus.raddr = 10'd100;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("t4_latency", 32'(lat), 32'd17);
    check("t4_done_count", 32'(dones), 32'd1);
    check("t4_busy_cycles", 32'(busy_n), 32'd16);
    check("t4_data_final", 32'(bus.data), 32'h0000_FF77);

    // Asynchronous reset in the middle of a computation
    bus.start = 1'b1;
    bus.raddr = 10'd120;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy_rst", 32'(bus.busy), 32'd0);
    check("t5_done_rst", 32'(bus.done), 32'd0);
    check("t5_data_rst", 32'(bus.data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_after", 32'(bus.busy), 32'd0);
    run_job(10'd200, lat, busy_n, d);
    check("t5_latency", 32'(lat), 32'd17);
    check("t5_data", 32'(d), 32'h0000_B4B4);
    @(negedge clk);

    // Start accepted in the DONE cycle
    run_job(10'd240, lat, busy_n, d);
    check("t6_first_data", 32'(d), 32'h0000_AAAA);
    check("t6_first_done", 32'(bus.done), 32'd1);
    run_job(10'd2, lat, busy_n, d);
    check("t6_latency", 32'(lat), 32'd17);
    check("t6_data", 32'(d), 32'h0000_FEF0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
